// File: rtl/ssd_scan_driver_pkg.sv
// Shared types, constants and segment encoding for the seven-segment scan driver.
package ssd_scan_driver_pkg;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned BCD_W  = 16;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned AN_W   = 4;

    localparam logic [SEG_W-1:0] SSD_OFF   = 7'h7F;
    localparam logic [AN_W-1:0]  ANODE_OFF = 4'hF;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_t;

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles are blank.
    function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] nib);
        logic [SEG_W-1:0] seg;
        case (nib)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_scan_driver_bin2bcd.sv
// Sequential double-dabble converter; bcd holds the last complete result,
// done is a sticky flag set by the first completed conversion after reset.
module bin2bcd_seq
    import ssd_scan_driver_pkg::*;
#(
    parameter int unsigned IN_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    localparam int unsigned ITER_W = $clog2(IN_W + 1);

    conv_state_t       state, state_next;
    logic [IN_W-1:0]   bin_q, bin_next;
    logic [BCD_W-1:0]  scratch, scratch_next;
    logic [BCD_W-1:0]  adj_c;
    logic [ITER_W-1:0] iter, iter_next;
    logic [BCD_W-1:0]  bcd_next;
    logic              done_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CONV_IDLE;
            bin_q   <= '0;
            scratch <= '0;
            iter    <= '0;
            bcd     <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            bin_q   <= bin_next;
            scratch <= scratch_next;
            iter    <= iter_next;
            bcd     <= bcd_next;
            done    <= done_next;
        end
    end

    always_comb begin
        state_next   = state;
        bin_next     = bin_q;
        scratch_next = scratch;
        iter_next    = iter;
        bcd_next     = bcd;
        done_next    = done;

        // Add-3 correction ahead of each shift keeps every nibble decimal.
        adj_c = scratch;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (scratch[4*k +: 4] >= 4'd5) begin
                adj_c[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
            end
        end

        case (state)
            CONV_IDLE: begin
                bin_next     = bin;
                scratch_next = '0;
                iter_next    = '0;
                state_next   = CONV_SHIFT;
            end
            CONV_SHIFT: begin
                {scratch_next, bin_next} = {adj_c[BCD_W-2:0], bin_q, 1'b0};
                iter_next = iter + ITER_W'(1);
                if (iter == ITER_W'(IN_W - 1)) begin
                    state_next = CONV_DONE;
                end
            end
            CONV_DONE: begin
                bcd_next   = scratch;
                done_next  = 1'b1;
                state_next = CONV_IDLE;
            end
            default: state_next = CONV_IDLE;
        endcase
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment driver fed by a binary value.
// Optional build macro: SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module ssd_scan_driver
    import ssd_scan_driver_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned IN_W        = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  value,
    output logic [AN_W-1:0]  anode,
    output logic [SEG_W-1:0] cathode,
    output logic             dp,
    output logic [BCD_W-1:0] bcd_out,
    output logic             bcd_valid
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [3:0]       nib_c;
    logic             blank_c;
    logic [SEG_W-1:0] seg_c;

    bin2bcd_seq #(.IN_W(IN_W)) u_bin2bcd (
        .clk  (clk),
        .rst  (rst),
        .bin  (value),
        .bcd  (bcd_out),
        .done (bcd_valid)
    );

    // Segment pattern for the digit currently selected by idx.
    always_comb begin
        nib_c   = bcd_out[{idx, 2'b00} +: 4];
        blank_c = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        blank_c = (idx != 2'd0) && ((bcd_out >> {idx, 2'b00}) == '0);
`endif
        seg_c = (!bcd_valid || blank_c) ? SSD_OFF : seg_encode(nib_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= 2'd0;
            anode   <= ANODE_OFF;
            cathode <= SSD_OFF;
            dp      <= 1'b1;
        end else begin
            if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            anode   <= ~(AN_W'(1) << idx);
            cathode <= seg_c;
            dp      <= 1'b1;
        end
    end

endmodule
